// File: rtl/frame_reader.sv
// Frame reader: once the upstream FIFO holds a whole frame, read it out through
// a 2-entry skid buffer onto a valid/ready stream, tagging the final word.
module frame_reader #(
  parameter int WORDS_PER_FRAME = 1280,
  parameter int DATA_WIDTH      = 32,
  parameter int COUNT_WIDTH     = 14
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   trigger_i,
  input  logic                   fifo_empty_i,
  input  logic [COUNT_WIDTH-1:0] fifo_rd_data_count_i,
  output logic                   fifo_rd_en_o,
  input  logic [DATA_WIDTH-1:0]  fifo_dout_i,
  output logic [DATA_WIDTH-1:0]  m_data_o,
  output logic                   m_valid_o,
  output logic                   m_last_o,
  input  logic                   m_ready_i,
  output logic                   busy_o,
  output logic                   frame_done_o,
  output logic [15:0]            frame_count_o,
  output logic                   underrun_o
);

  localparam int IW = $clog2(WORDS_PER_FRAME + 1);
  localparam logic [IW-1:0]          FRAME_LEN = IW'(WORDS_PER_FRAME);
  localparam logic [IW-1:0]          LAST_IDX  = IW'(WORDS_PER_FRAME - 1);
  localparam logic [COUNT_WIDTH-1:0] MIN_COUNT = COUNT_WIDTH'(WORDS_PER_FRAME);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                state, state_next;
  logic [IW-1:0]         issued;
  logic                  in_flight, in_flight_last;
  logic [DATA_WIDTH-1:0] buf_data [2];
  logic [1:0]            buf_last;
  logic                  head;
  logic [1:0]            occ;
  logic                  start, pop, wr_idx, last_xfer, room;

  assign pop       = m_valid_o && m_ready_i;
  assign m_valid_o = (occ != 2'd0);
  assign m_data_o  = buf_data[head];
  assign m_last_o  = m_valid_o && buf_last[head];
  assign busy_o    = (state != IDLE);
  assign last_xfer = pop && m_last_o;
  // Returning word lands behind the head entry; a same-cycle pop frees head first.
  assign wr_idx    = head ^ occ[0];
  assign start     = (state == IDLE) && trigger_i && !fifo_empty_i &&
                     (fifo_rd_data_count_i >= MIN_COUNT);
  // Only issue if the word returning next cycle is guaranteed a free slot.
  assign room      = ({1'b0, occ} + {2'b00, in_flight}) < (3'd2 + {2'b00, pop});

  always_comb begin
    state_next   = state;
    fifo_rd_en_o = 1'b0;
    unique case (state)
      IDLE:  if (start) state_next = READ;
      READ: begin
        fifo_rd_en_o = !fifo_empty_i && (issued < FRAME_LEN) && room;
        if (fifo_rd_en_o && (issued == LAST_IDX)) state_next = DRAIN;
      end
      DRAIN: if (last_xfer) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      issued         <= '0;
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
      occ            <= '0;
      head           <= 1'b0;
      buf_last       <= '0;
      buf_data[0]    <= '0;
      buf_data[1]    <= '0;
      frame_done_o   <= 1'b0;
      frame_count_o  <= '0;
      underrun_o     <= 1'b0;
    end else begin
      state          <= state_next;
      in_flight      <= fifo_rd_en_o;
      in_flight_last <= fifo_rd_en_o && (issued == LAST_IDX);
      if (start)
        issued <= '0;
      else if (fifo_rd_en_o)
        issued <= issued + IW'(1);
      if (in_flight) begin
        buf_data[wr_idx] <= fifo_dout_i;
        buf_last[wr_idx] <= in_flight_last;
      end
      if (in_flight && !pop)
        occ <= occ + 2'd1;
      else if (!in_flight && pop)
        occ <= occ - 2'd1;
      if (pop)
        head <= ~head;
      frame_done_o <= (state == DRAIN) && last_xfer;
      if ((state == DRAIN) && last_xfer)
        frame_count_o <= frame_count_o + 16'd1;
      if ((state == READ) && fifo_empty_i && (issued < FRAME_LEN))
        underrun_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_reader.sv
// Scoreboard bench for frame_reader: a FIFO model feeds the DUT, expected words
// are queued at frame start and a negedge monitor checks every transfer.
module tb_frame_reader;
  localparam int W  = 1280;
  localparam int DW = 32;
  localparam int CW = 14;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          trigger_i = 1'b0;
  logic          fifo_empty_i = 1'b1;
  logic [CW-1:0] fifo_rd_data_count_i = '0;
  logic          fifo_rd_en_o;
  logic [DW-1:0] fifo_dout_i = '0;
  logic [DW-1:0] m_data_o;
  logic          m_valid_o, m_last_o;
  logic          m_ready_i = 1'b1;
  logic          busy_o, frame_done_o, underrun_o;
  logic [15:0]   frame_count_o;

  always #5 clk = ~clk;

  frame_reader #(.WORDS_PER_FRAME(W), .DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .trigger_i(trigger_i), .fifo_empty_i(fifo_empty_i),
    .fifo_rd_data_count_i(fifo_rd_data_count_i), .fifo_rd_en_o(fifo_rd_en_o),
    .fifo_dout_i(fifo_dout_i), .m_data_o(m_data_o), .m_valid_o(m_valid_o),
    .m_last_o(m_last_o), .m_ready_i(m_ready_i), .busy_o(busy_o),
    .frame_done_o(frame_done_o), .frame_count_o(frame_count_o), .underrun_o(underrun_o)
  );

  logic [DW:0]   exp_q [$];
  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] next_word = 32'hA500_0000;
  int vectors = 0, miscompares = 0, cyc = 0;
  int rd_total = 0, xfer_total = 0, done_total = 0, rd_base = 0;
  int rd_at_start = 0, xfer_at_start = 0, start_cyc = 0;
  int first_rd = 0, first_valid = 0, last_xfer_k = 0;
  int stall_left = 0;
  bit timing_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Source FIFO model: registered read data, flags updated on the same edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en_o) begin
      vectors++;
      if (fifo_empty_i || fifo_q.size() == 0) begin
        miscompares++;
        $display("FAIL read_while_empty: got rd_en=1 expected 0 (t=%0t)", $time);
      end else begin
        fifo_dout_i <= fifo_q.pop_front();
      end
    end
    fifo_empty_i         <= (fifo_q.size() == 0) || (stall_left > 0);
    fifo_rd_data_count_i <= CW'(fifo_q.size());
  end

  // Monitor
  logic [DW:0] prev_word = '0;
  bit prev_stall = 0, prev_last_xfer = 0;
  always @(negedge clk) begin
    int k;
    k = cyc - start_cyc + 1;
    if (!reset) begin
      if (fifo_rd_en_o) begin
        rd_total++;
        if (timing_en && first_rd == 0) first_rd = k;
      end
      if (m_valid_o && timing_en && first_valid == 0) first_valid = k;
      if (prev_stall) begin
        check("hold_valid", m_valid_o, 1);
        check("hold_word", {m_last_o, m_data_o}, prev_word);
      end
      if (m_valid_o && m_ready_i) begin
        xfer_total++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_word: got %0h expected none", {m_last_o, m_data_o});
        end else begin
          check("word", {m_last_o, m_data_o}, exp_q.pop_front());
        end
        if (m_last_o && timing_en) last_xfer_k = k;
      end
      if (busy_o) check("outstanding_le3", (rd_total - xfer_total - rd_base) <= 3, 1);
      if (frame_done_o) begin
        done_total++;
        check("done_after_last", prev_last_xfer, 1);
      end
      prev_stall     = m_valid_o && !m_ready_i;
      prev_word      = {m_last_o, m_data_o};
      prev_last_xfer = m_valid_o && m_ready_i && m_last_o;
    end else begin
      prev_stall     = 0;
      prev_last_xfer = 0;
    end
  end

  task automatic load(input int n);
    repeat (n) begin
      fifo_q.push_back(next_word);
      next_word = next_word + 32'h0001_0003;
    end
    @(posedge clk); #2;
  endtask

  task automatic expect_frames(input int n);
    for (int i = 0; i < n * W; i++)
      exp_q.push_back({((i % W) == W - 1), fifo_q[i]});
  endtask

  task automatic start_frame(input bit hold);
    trigger_i     = 1'b1;
    rd_at_start   = rd_total;
    xfer_at_start = xfer_total;
    @(posedge clk); #1;
    start_cyc = cyc;
    #1;
    if (!hold) trigger_i = 1'b0;
  endtask

  // mode 0: ready high; 1: random ready with a 5-cycle low; 2: 10-cycle FIFO
  // stall after 600 reads; 3: return once 700 words have transferred.
  task automatic wait_done(input int mode, input int budget);
    bit seen = 0, stalled = 0, quit = 0;
    int n = 0;
    while (!seen && !quit && n < budget) begin
      if (mode == 1)
        m_ready_i = (n >= 100 && n < 105) ? 1'b0 : 1'($urandom_range(0, 1));
      else
        m_ready_i = 1'b1;
      if (stall_left > 0) stall_left--;
      if (mode == 2 && !stalled && (rd_total - rd_at_start) >= 600) begin
        stall_left = 10;
        stalled    = 1;
      end
      if (mode == 3 && (xfer_total - xfer_at_start) >= 700) quit = 1;
      else begin
        @(posedge clk); #2;
        n++;
        if (frame_done_o) seen = 1;
      end
    end
    m_ready_i = 1'b1;
    if (!seen && !quit) begin
      vectors++;
      miscompares++;
      $display("FAIL frame_timeout: got no frame_done expected one within %0d cycles", budget);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", m_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_rd_en", fifo_rd_en_o, 0);
    check("rst_count", frame_count_o, 0);
    check("rst_underrun", underrun_o, 0);
    check("rst_done", frame_done_o, 0);
    #1 reset = 1'b0;

    // Nominal frame with cycle-accurate latency
    load(2 * W);
    expect_frames(1);
    d0 = done_total;
    timing_en = 1;
    start_frame(0);
    wait_done(0, W + 100);
    repeat (4) @(posedge clk);
    #2;
    timing_en = 0;
    check("first_rd_cycle", first_rd, 1);
    check("first_valid_cycle", first_valid, 3);
    check("last_xfer_cycle", last_xfer_k, W + 2);
    check("nominal_reads", rd_total - rd_at_start, W);
    check("nominal_xfers", xfer_total - xfer_at_start, W);
    check("nominal_done_pulses", done_total - d0, 1);
    check("nominal_count", frame_count_o, 1);
    check("nominal_exp_empty", exp_q.size(), 0);
    check("nominal_busy", busy_o, 0);
    check("nominal_underrun", underrun_o, 0);

    // Insufficient data
    fifo_q.delete();
    load(W - 1);
    trigger_i = 1'b1;
    repeat (10) begin
      @(posedge clk); #2;
      check("short_rd_en", fifo_rd_en_o, 0);
      check("short_busy", busy_o, 0);
    end
    trigger_i = 1'b0;

    // Backpressure
    fifo_q.delete();
    load(W);
    expect_frames(1);
    start_frame(0);
    wait_done(1, 8 * W);
    check("bp_xfers", xfer_total - xfer_at_start, W);
    check("bp_exp_empty", exp_q.size(), 0);
    check("bp_count", frame_count_o, 2);
    check("bp_underrun", underrun_o, 0);

    // Underrun
    fifo_q.delete();
    load(W);
    expect_frames(1);
    start_frame(0);
    wait_done(2, W + 200);
    check("ur_flag", underrun_o, 1);
    check("ur_xfers", xfer_total - xfer_at_start, W);
    check("ur_reads", rd_total - rd_at_start, W);
    check("ur_exp_empty", exp_q.size(), 0);
    check("ur_count", frame_count_o, 3);
    repeat (5) @(posedge clk);
    #2 check("ur_sticky", underrun_o, 1);

    // Reset mid-frame
    fifo_q.delete();
    load(W);
    expect_frames(1);
    start_frame(0);
    wait_done(3, W + 100);
    check("pre_reset_busy", busy_o, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_rd_en", fifo_rd_en_o, 0);
    check("mid_rst_valid", m_valid_o, 0);
    check("mid_rst_last", m_last_o, 0);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_done", frame_done_o, 0);
    check("mid_rst_count", frame_count_o, 0);
    check("mid_rst_underrun", underrun_o, 0);
    reset = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    #1 rd_base = rd_total - xfer_total;
    load(W);
    expect_frames(1);
    start_frame(0);
    wait_done(0, W + 100);
    check("post_rst_xfers", xfer_total - xfer_at_start, W);
    check("post_rst_count", frame_count_o, 1);
    check("post_rst_exp_empty", exp_q.size(), 0);

    // Back-to-back frames with counter wrap
    fifo_q.delete();
    load(3 * W);
    expect_frames(3);
    force dut.frame_count_o = 16'hFFFF;
    @(posedge clk); #2;
    release dut.frame_count_o;
    start_frame(1);
    for (int f = 0; f < 3; f++) begin
      wait_done(0, W + 100);
      check("b2b_count", frame_count_o, 64'(f));
      if (f < 2) begin
        check("b2b_idle_on_done", busy_o, 0);
        @(posedge clk); #2;
        check("b2b_restart_busy", busy_o, 1);
        check("b2b_restart_rd", fifo_rd_en_o, 1);
      end
    end
    trigger_i = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("b2b_reads", rd_total - rd_at_start, 3 * W);
    check("b2b_exp_empty", exp_q.size(), 0);
    check("b2b_final_busy", busy_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/frame_reader.md
FRAME_READER -- requirements
Module: frame_reader

Interface
REQ-001 Parameter WORDS_PER_FRAME, default 1280: number of FIFO words in one frame.
REQ-002 Parameter DATA_WIDTH, default 32: width of the FIFO word and the output stream word.
REQ-003 Parameter COUNT_WIDTH, default 14: width of the FIFO read-data-count input.
REQ-004 Port clk, input, 1: single clock; all logic is on posedge clk.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port trigger_i, input, 1: frame-band trigger from the upstream FIFO-level trigger stage.
REQ-007 Port fifo_empty_i, input, 1: source FIFO empty flag.
REQ-008 Port fifo_rd_data_count_i, input, COUNT_WIDTH: number of words readable in the source FIFO.
REQ-009 Port fifo_rd_en_o, output, 1: source FIFO read strobe; data returns one cycle later.
REQ-010 Port fifo_dout_i, input, DATA_WIDTH: source FIFO read data, valid in the cycle after fifo_rd_en_o.
REQ-011 Port m_data_o, output, DATA_WIDTH: output stream data.
REQ-012 Port m_valid_o, output, 1: output stream valid.
REQ-013 Port m_last_o, output, 1: marks the final word of a frame.
REQ-014 Port m_ready_i, input, 1: downstream ready.
REQ-015 Port busy_o, output, 1: high while a frame transfer is in progress.
REQ-016 Port frame_done_o, output, 1: one-cycle pulse when a frame's last word is accepted.
REQ-017 Port frame_count_o, output, 16: completed-frame counter; wraps from 0xFFFF to 0.
REQ-018 Port underrun_o, output, 1: sticky flag; FIFO ran empty mid-frame.

Function
REQ-019 The FSM SHALL have states IDLE, READ and DRAIN.
REQ-020 Start condition: IDLE && trigger_i && !fifo_empty_i && fifo_rd_data_count_i >= WORDS_PER_FRAME; when true at an edge, the FSM SHALL go to READ and clear the issued-word counter.
REQ-021 In READ, fifo_rd_en_o SHALL be high when all of these hold: !fifo_empty_i; issued < WORDS_PER_FRAME; (occupancy + in_flight - pop) < 2.
REQ-022 In that condition, occupancy is the 2-entry output buffer level, in_flight is a read issued last cycle, and pop is m_valid_o && m_ready_i this cycle.
REQ-023 fifo_rd_en_o SHALL never be high outside READ.
REQ-024 The data word returned in the cycle after each read SHALL be written into the 2-entry output buffer; the buffer SHALL never overflow.
REQ-025 A word SHALL be transferred when m_valid_o && m_ready_i; m_data_o and m_last_o SHALL be held stable while m_valid_o is high and m_ready_i is low.
REQ-026 m_last_o SHALL be high only on the buffer entry holding word index WORDS_PER_FRAME-1 of the frame.
REQ-027 When issued reaches WORDS_PER_FRAME, the FSM SHALL go from READ to DRAIN.
REQ-028 DRAIN SHALL go to IDLE on the edge where the m_last_o word is transferred; on that edge frame_done_o pulses and frame_count_o increments.
REQ-029 With m_ready_i held high and the FIFO non-empty, the first fifo_rd_en_o SHALL be in cycle 1 after the start edge (E0), the first m_valid_o in cycle 3, and one word SHALL transfer per cycle thereafter.
REQ-030 Under the REQ-029 conditions, the last word SHALL transfer in cycle WORDS_PER_FRAME+2 after E0.
REQ-031 If fifo_empty_i is high in READ while issued < WORDS_PER_FRAME, reads SHALL stall without losing or duplicating words, and underrun_o SHALL be set and held until reset.
REQ-032 trigger_i SHALL be ignored in READ and DRAIN; a new frame starts only from IDLE.
REQ-033 A new frame may start on the edge after frame_done_o if the start condition holds.
REQ-034 busy_o SHALL equal (state != IDLE).

Reset
REQ-035 On reset, all of the following SHALL be 0 on the next edge, regardless of state or data in flight: state IDLE, the buffer and counters cleared, fifo_rd_en_o, m_valid_o, m_last_o, busy_o, frame_done_o, frame_count_o and underrun_o.
REQ-036 A read in flight at reset SHALL be discarded.

Verification
REQ-037 Nominal frame: FIFO holds 2560 words, trigger_i=1, m_ready_i=1 -> exactly 1280 reads; words transfer in order in cycles 3..1282; m_last_o on word 1279 only; frame_done_o pulses; frame_count_o=1.
REQ-038 Insufficient data: count=1279, trigger_i=1 -> fifo_rd_en_o stays 0; busy_o=0.
REQ-039 Backpressure: m_ready_i toggled randomly, including low for 5 cycles -> no word lost or duplicated, m_data_o stable while stalled, buffer never exceeds 2 entries.
REQ-040 Underrun: fifo_empty_i forced high for 10 cycles after word 600 -> reads stall, underrun_o=1 sticky, frame still completes with 1280 ordered words.
REQ-041 Reset mid-frame: reset asserted after word 700 -> all outputs 0 next cycle; a fresh start later delivers a full 1280-word frame.
REQ-042 Back-to-back and wrap: 3 consecutive frames -> frame 2 starts on the edge after frame_done_o; frame_count_o preloaded to 0xFFFF wraps to 0.
